// File: rtl/img_pix_fifo_reader.sv
// ----------------------------------------------------------------------------
// img_pix_fifo_reader : pixel-source reader buffering into a FIFO, Avalon-MM slave
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module img_pix_fifo_reader #(
  parameter int PIX_W       = 24,
  parameter int FIFO_DEPTH  = 16,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             get_next_pix,
  input  logic             pix_rdy,
  input  logic [PIX_W-1:0] pixel_data,
  input  logic             img_done,
  output logic             cpu_rdy,
  output logic [3:0]       out_state,
  output logic [31:0]      pix_count,
  output logic [PIX_W-1:0] pix_rgb_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_REQ  = 4'd1,
    S_WAIT = 4'd2,
    S_DONE = 4'd3,
    S_ERR  = 4'd4
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     level_q, level_d;
  logic [31:0]       pix_count_q, pix_count_d;
  logic [31:0]       tmo_q, tmo_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              underflow_q, underflow_d;
  logic              drop_q, drop_d;
  logic              gnp_q, gnp_d;
  logic [PIX_W-1:0]  mem_q [FIFO_DEPTH];

  logic              empty, full, ctrl_wr, start, abort, flush;
  logic              rd_data, pop, push;
  logic [PIX_W-1:0]  head;
  logic [31:0]       status;
  logic              unused_wdata;

  assign empty   = (level_q == '0);
  assign full    = (level_q == CW'(FIFO_DEPTH));
  assign head    = empty ? '0 : mem_q[rd_ptr_q];
  assign ctrl_wr = avs_write && (avs_address == 2'd0);
  // Abort dominates start when both bits are written together.
  assign abort   = ctrl_wr && avs_writedata[1];
  assign start   = ctrl_wr && avs_writedata[0] && !avs_writedata[1];
  assign flush   = start || abort;
  assign rd_data = avs_read && (avs_address == 2'd2);
  assign pop     = rd_data && !empty;
  assign push    = (state_q == S_WAIT) && pix_rdy && !flush;

  assign status = {16'(level_q), 10'd0, drop_q, underflow_q,
                   (state_q == S_ERR), (state_q == S_DONE), full, empty};

  assign unused_wdata = ^avs_writedata[31:2];

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    level_d     = level_q;
    pix_count_d = pix_count_q;
    tmo_d       = tmo_q;
    rdata_d     = rdata_q;
    underflow_d = underflow_q;
    drop_d      = drop_q;
    gnp_d       = 1'b0;

    // Read data always reflects state before this cycle's updates.
    if (avs_read) begin
      case (avs_address)
        2'd0:    rdata_d = {28'd0, state_q};
        2'd1:    rdata_d = status;
        2'd2:    rdata_d = 32'(head);
        default: rdata_d = pix_count_q;
      endcase
    end

    if (rd_data && empty)                underflow_d = 1'b1;
    if (pix_rdy && (state_q != S_WAIT))  drop_d      = 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push) begin
      wr_ptr_d    = wr_ptr_q + 1'b1;
      pix_count_d = pix_count_q + 32'd1;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    case (state_q)
      S_REQ: begin
        if (!full) begin
          gnp_d   = 1'b1;
          tmo_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (img_done)
          state_d = S_DONE;
        else if (pix_rdy)
          state_d = S_REQ;
        else if ((TIMEOUT_CYC > 0) && (tmo_q == 32'(TIMEOUT_CYC - 1)))
          state_d = S_ERR;
        else
          tmo_d = tmo_q + 32'd1;
      end
      default: ;
    endcase

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
      gnp_d    = 1'b0;
      state_d  = abort ? S_IDLE : S_REQ;
    end
    if (start) begin
      pix_count_d = '0;
      underflow_d = 1'b0;
      drop_d      = 1'b0;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= S_IDLE;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      level_q     <= '0;
      pix_count_q <= '0;
      tmo_q       <= '0;
      rdata_q     <= '0;
      underflow_q <= 1'b0;
      drop_q      <= 1'b0;
      gnp_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      level_q     <= level_d;
      pix_count_q <= pix_count_d;
      tmo_q       <= tmo_d;
      rdata_q     <= rdata_d;
      underflow_q <= underflow_d;
      drop_q      <= drop_d;
      gnp_q       <= gnp_d;
    end
  end

  // Storage needs no reset: the level gates everything visible.
  always_ff @(posedge clk_clk) begin
    if (push) mem_q[wr_ptr_q] <= pixel_data;
  end

  assign avs_readdata = rdata_q;
  assign get_next_pix = gnp_q;
  assign cpu_rdy      = !empty;
  assign out_state    = state_q;
  assign pix_count    = pix_count_q;
  assign pix_rgb_out  = head;

endmodule

`default_nettype wire

// File: tb/tb_img_pix_fifo_reader.sv
// ----------------------------------------------------------------------------
// tb_img_pix_fifo_reader : randomized bench with a queue-based reference model
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_img_pix_fifo_reader;

  localparam int PIX_W = 24;
  localparam int DEPTH = 16;
  localparam int TMO   = 8;

  logic             clk_clk = 1'b0;
  logic             reset_reset_n = 1'b0;
  logic [1:0]       avs_address = '0;
  logic             avs_read = 1'b0;
  logic             avs_write = 1'b0;
  logic [31:0]      avs_writedata = '0;
  logic [31:0]      avs_readdata;
  logic             get_next_pix;
  logic             pix_rdy = 1'b0;
  logic [PIX_W-1:0] pixel_data = '0;
  logic             img_done = 1'b0;
  logic             cpu_rdy;
  logic [3:0]       out_state;
  logic [31:0]      pix_count;
  logic [PIX_W-1:0] pix_rgb_out;

  always #5 clk_clk = ~clk_clk;

  img_pix_fifo_reader #(.PIX_W(PIX_W), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .get_next_pix(get_next_pix), .pix_rdy(pix_rdy), .pixel_data(pixel_data),
    .img_done(img_done), .cpu_rdy(cpu_rdy), .out_state(out_state),
    .pix_count(pix_count), .pix_rgb_out(pix_rgb_out)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: FIFO contents, counter and sticky flags.
  logic [PIX_W-1:0] mq[$];
  logic [31:0]      m_cnt = 0;
  bit               m_uf = 0, m_drop = 0;

  // Pixel source model.
  logic [PIX_W-1:0] sq[$];
  bit               src_pend = 0, src_hang = 0, done_last = 0, extra_rdy = 0;
  int               src_dly = 0;
  int               pulses = 0;
  logic [31:0]      last_rd = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_status(input bit done, input bit err);
    return {16'(mq.size()), 10'd0, m_drop, m_uf, err, done,
            (mq.size() == DEPTH), (mq.size() == 0)};
  endfunction

  // One clock cycle: drive at a negedge, update the model, observe at next negedge.
  task automatic step(input bit rd, input bit wr, input logic [1:0] a, input logic [31:0] wd);
    logic [31:0] exp_rd;
    bit          rd_dat;
    avs_read      = rd;
    avs_write     = wr;
    avs_address   = a;
    avs_writedata = wd;
    pix_rdy       = extra_rdy;
    img_done      = 1'b0;
    pixel_data    = '0;
    if (extra_rdy) m_drop = 1;
    rd_dat = rd && (a == 2'd2);
    exp_rd = 0;
    if (rd_dat) begin
      if (mq.size() > 0) exp_rd = 32'(mq.pop_front());
      else m_uf = 1;
    end
    if (src_pend) begin
      if (src_dly > 0) src_dly--;
      else if (sq.size() > 0) begin
        pixel_data = sq.pop_front();
        pix_rdy    = 1'b1;
        mq.push_back(pixel_data);
        m_cnt++;
        if (sq.size() == 0 && done_last) img_done = 1'b1;
        src_pend = 0;
      end else if (!src_hang) begin
        img_done = 1'b1;
        src_pend = 0;
      end
    end
    if (wr && a == 2'd0) begin
      if (wd[1]) mq.delete();
      else if (wd[0]) begin
        mq.delete();
        m_cnt  = 0;
        m_uf   = 0;
        m_drop = 0;
      end
    end
    @(negedge clk_clk);
    if (rd) begin
      last_rd = avs_readdata;
      if (rd_dat) check_eq("data_rd", avs_readdata, exp_rd);
    end
    if (get_next_pix) begin
      pulses++;
      src_pend = 1;
      src_dly  = $urandom_range(0, 3);
    end
    check_eq("cpu_rdy", 32'(cpu_rdy), 32'(mq.size() != 0));
    check_eq("peek", 32'(pix_rgb_out), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
    check_eq("pix_count", pix_count, m_cnt);
    avs_read  = 1'b0;
    avs_write = 1'b0;
    pix_rdy   = 1'b0;
    img_done  = 1'b0;
    extra_rdy = 0;
  endtask

  task automatic reg_rd(input logic [1:0] a, input string tag, input logic [31:0] exp);
    step(1, 0, a, 0);
    check_eq(tag, last_rd, exp);
  endtask

  task automatic ctrl(input logic [31:0] v);
    step(0, 1, 2'd0, v);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic run_image(input int rp);
    ctrl(32'd1);
    pulses = 0;
    for (int k = 0; k < 800 && out_state != 4'd3; k++) begin
      if ($urandom_range(99) < rp) step(1, 0, 2'd2, 0);
      else step(0, 0, 0, 0);
    end
    check_eq("reach_done", 32'(out_state), 32'd3);
  endtask

  task automatic drain();
    for (int k = 0; k < 64 && mq.size() > 0; k++) step(1, 0, 2'd2, 0);
  endtask

  initial begin
    #1;
    check_eq("rst_state", 32'(out_state), 0);
    check_eq("rst_rdata", avs_readdata, 0);
    check_eq("rst_gnp", 32'(get_next_pix), 0);
    check_eq("rst_cpu_rdy", 32'(cpu_rdy), 0);
    check_eq("rst_count", pix_count, 0);
    check_eq("rst_peek", 32'(pix_rgb_out), 0);
    repeat (3) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    reg_rd(2'd1, "rst_status", 32'h1);

    // Five pixels, last one accompanied by img_done.
    sq = '{24'h1, 24'h2, 24'h3, 24'h4, 24'h5};
    done_last = 1;
    run_image(0);
    check_eq("img5_pulses", pulses, 5);
    reg_rd(2'd3, "img5_count", 32'd5);
    reg_rd(2'd1, "img5_status", exp_status(1, 0));
    for (int i = 1; i <= 5; i++) begin
      step(1, 0, 2'd2, 0);
      check_eq("img5_order", last_rd, i);
    end

    // Underflow on empty DATA read.
    step(1, 0, 2'd2, 0);
    check_eq("uf_rdata", last_rd, 0);
    reg_rd(2'd1, "uf_status", exp_status(1, 0));
    check_eq("uf_bit", (last_rd >> 4) & 32'h1, 1);

    // Overfill: 20 pixels offered, no reads.
    sq.delete();
    for (int i = 0; i < 20; i++) sq.push_back(24'h100 + 24'(i));
    done_last = 1;
    ctrl(32'd1);
    pulses = 0;
    idle(150);
    reg_rd(2'd0, "full_state", 32'd1);
    reg_rd(2'd1, "full_status", exp_status(0, 0));
    check_eq("full_level", last_rd >> 16, 16);
    check_eq("full_pulses", pulses, 16);
    step(1, 0, 2'd2, 0);
    check_eq("full_first", last_rd, 32'h100);
    idle(20);
    check_eq("refill_pulses", pulses, 17);
    reg_rd(2'd1, "refill_status", exp_status(0, 0));
    sq.delete();
    src_pend = 0;
    ctrl(32'd3);
    reg_rd(2'd0, "abort_state", 32'd0);
    reg_rd(2'd1, "abort_status", exp_status(0, 0));

    // Last pixel and img_done in the same cycle.
    sq = '{24'h11, 24'h22, 24'hABCDEF};
    done_last = 1;
    run_image(0);
    reg_rd(2'd0, "same_state", 32'd3);
    reg_rd(2'd3, "same_count", 32'd3);
    drain();
    check_eq("same_last", last_rd, 32'hABCDEF);

    // pix_rdy outside WAIT raises drop.
    extra_rdy = 1;
    step(0, 0, 0, 0);
    reg_rd(2'd1, "drop_status", exp_status(1, 0));

    // Silent source: timeout into ERR.
    src_hang = 1;
    sq.delete();
    ctrl(32'd1);
    pulses = 0;
    for (int i = 0; i < 5 && pulses == 0; i++) step(0, 0, 0, 0);
    begin
      int n;
      n = 0;
      while (out_state != 4'd4 && n < 20) begin
        step(0, 0, 0, 0);
        n++;
      end
      check_eq("tmo_cycles", n, TMO);
    end
    reg_rd(2'd1, "err_status", exp_status(0, 1));
    src_pend = 0;
    ctrl(32'd2);
    reg_rd(2'd0, "err_abort", 32'd0);

    // Reset in WAIT with three pixels buffered.
    sq = '{24'h7, 24'h8, 24'h9};
    done_last = 0;
    ctrl(32'd1);
    pulses = 0;
    for (int i = 0; i < 100 && pulses < 4; i++) step(0, 0, 0, 0);
    reg_rd(2'd3, "pre_rst_count", 32'd3);
    reg_rd(2'd1, "pre_rst_status", exp_status(0, 0));
    check_eq("pre_rst_state", 32'(out_state), 2);
    reset_reset_n = 1'b0;
    #1;
    check_eq("arst_state", 32'(out_state), 0);
    check_eq("arst_rdata", avs_readdata, 0);
    check_eq("arst_cpu_rdy", 32'(cpu_rdy), 0);
    check_eq("arst_count", pix_count, 0);
    check_eq("arst_peek", 32'(pix_rgb_out), 0);
    check_eq("arst_gnp", 32'(get_next_pix), 0);
    mq.delete();
    sq.delete();
    m_cnt = 0; m_uf = 0; m_drop = 0;
    src_pend = 0; src_hang = 0;
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    reg_rd(2'd1, "post_rst_status", 32'h1);

    // Randomized images with interleaved CPU reads.
    for (int it = 0; it < 8; it++) begin
      int n;
      n = $urandom_range(1, 25);
      sq.delete();
      for (int i = 0; i < n; i++) sq.push_back(24'($urandom));
      done_last = $urandom_range(0, 1);
      run_image($urandom_range(0, 40));
      check_eq("rnd_pulses", pulses, n + (done_last ? 0 : 1));
      reg_rd(2'd3, "rnd_count", n);
      drain();
      reg_rd(2'd1, "rnd_status", exp_status(1, 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
